// File: rtl/rng_ram_if.sv
// rng_ram_if: bus bundle for the rng_ram scratch RAM + LFSR block.
//   seed     : LFSR load value (sampled by the block while reset is high)
//   rnd      : current LFSR state from the block
//   data_in  : RAM write data
//   w_addr   : RAM write address
//   w_enable : RAM write strobe, active-high
//   r_addr   : RAM read address
//   data_out : registered RAM read data from the block
// Modports: master drives the requests, slave is the rng_ram block.
interface rng_ram_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 6
);
    logic [31:0]           seed;
    logic [31:0]           rnd;
    logic [DATA_WIDTH-1:0] data_in;
    logic [ADDR_WIDTH-1:0] w_addr;
    logic                  w_enable;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] data_out;

    modport master (
        output seed, data_in, w_addr, w_enable, r_addr,
        input  rnd, data_out
    );

    modport slave (
        input  seed, data_in, w_addr, w_enable, r_addr,
        output rnd, data_out
    );
endinterface

// File: rtl/rng_ram.sv
// rng_ram: simple dual-port synchronous scratch RAM (one write port, one
// registered read port) paired with a 32-bit Fibonacci LFSR
// (x^32+x^22+x^2+x+1) used as a reproducible pseudo-random word source.
// Ports:
//   clk   : single clock, all state changes on the rising edge
//   reset : synchronous, active-high; reloads the LFSR from seed and clears
//           data_out; never touches the memory array
//   bus   : rng_ram_if.slave (seed, rnd, data_in, w_addr, w_enable,
//           r_addr, data_out)
module rng_ram #(
    parameter int  DATA_WIDTH = 8,
    parameter int  RAM_SIZE   = 64,
    localparam int ADDR_WIDTH = $clog2(RAM_SIZE)
) (
    input  logic      clk,
    input  logic      reset,
    rng_ram_if.slave  bus
);
    // One extra bit so the range compare also works when RAM_SIZE is a
    // power of two (RAM_SIZE itself does not fit in ADDR_WIDTH bits).
    localparam logic [ADDR_WIDTH:0] SIZE_L = (ADDR_WIDTH + 1)'(RAM_SIZE);

    logic [DATA_WIDTH-1:0] mem [RAM_SIZE];

    logic [31:0]           rnd_q, rnd_d;
    logic [31:0]           seed_load;
    logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
    logic                  w_in_range;
    logic                  r_in_range;

    always_comb begin
        w_in_range = ({1'b0, bus.w_addr} < SIZE_L);
        r_in_range = ({1'b0, bus.r_addr} < SIZE_L);

        // A zero seed would lock the LFSR in the all-zero state forever.
        seed_load = (bus.seed == 32'h0) ? 32'h0000_0001 : bus.seed;

        rnd_d = {rnd_q[30:0], rnd_q[31] ^ rnd_q[21] ^ rnd_q[1] ^ rnd_q[0]};

        // mem is read here before this edge's write lands, which gives
        // read-before-write on an address collision.
        data_out_d = '0;
        if (r_in_range) begin
            data_out_d = mem[bus.r_addr];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rnd_q      <= seed_load;
            data_out_q <= '0;
        end else begin
            rnd_q      <= rnd_d;
            data_out_q <= data_out_d;
        end
    end

    // The array has no reset; writes proceed even while reset is high.
    always_ff @(posedge clk) begin
        if (bus.w_enable && w_in_range) begin
            mem[bus.w_addr] <= bus.data_in;
        end
    end

    assign bus.rnd      = rnd_q;
    assign bus.data_out = data_out_q;
endmodule

// File: tb/tb_rng_ram.sv
// tb_rng_ram: directed + LFSR-sliced stimulus for rng_ram with a
// queue-based scoreboard. The driver updates a reference model on each
// negative edge and queues the expected outputs for the following rising
// edge; a monitor pops and compares shortly after each rising edge.
module tb_rng_ram;
    localparam int DW = 8;
    localparam int RS = 64;
    localparam int AW = 6;
    localparam int RAND_CYCLES = 20000;

    typedef struct {
        string       name;
        logic        chk_d;
        logic        chk_r;
        logic        chk_mem;
        logic [7:0]  exp_d;
        logic [31:0] exp_r;
    } exp_t;

    logic clk = 1'b0;
    logic reset;

    rng_ram_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    rng_ram #(.DATA_WIDTH(DW), .RAM_SIZE(RS)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    exp_t       sb_q[$];
    int         checks = 0;
    int         errors = 0;

    logic [7:0]  mem_m   [RS];
    logic        mem_vld [RS];
    logic [31:0] rnd_m;
    logic        rnd_vld;

    function automatic logic [31:0] lfsr_next(input logic [31:0] s);
        return {s[30:0], s[31] ^ s[21] ^ s[1] ^ s[0]};
    endfunction

    // Drive one cycle of inputs at the negative edge, advance the model
    // through the coming rising edge and queue what the DUT must show.
    task automatic step(input logic rst, input logic [31:0] sd,
                        input logic [7:0] din, input logic [5:0] wa,
                        input logic we, input logic [5:0] ra,
                        input logic chk_mem, input string name);
        exp_t e;
        @(negedge clk);
        reset        = rst;
        bus.seed     = sd;
        bus.data_in  = din;
        bus.w_addr   = wa;
        bus.w_enable = we;
        bus.r_addr   = ra;
        e.name    = name;
        e.chk_mem = chk_mem;
        if (rst) begin
            e.chk_d = 1'b1;
            e.exp_d = 8'h00;
            rnd_m   = (sd == 32'h0) ? 32'h1 : sd;
            rnd_vld = 1'b1;
        end else begin
            e.chk_d = mem_vld[ra];
            e.exp_d = mem_m[ra];
            if (rnd_vld) rnd_m = lfsr_next(rnd_m);
        end
        e.chk_r = rnd_vld;
        e.exp_r = rnd_m;
        if (we) begin
            mem_m[wa]   = din;
            mem_vld[wa] = 1'b1;
        end
        sb_q.push_back(e);
    endtask

    // Monitor: compare just after each rising edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                if (e.chk_d) begin
                    checks++;
                    if (bus.data_out !== e.exp_d) begin
                        errors++;
                        $display("FAIL %s data_out: got %h want %h", e.name, bus.data_out, e.exp_d);
                    end
                end
                if (e.chk_r) begin
                    checks++;
                    if (bus.rnd !== e.exp_r || bus.rnd == 32'h0) begin
                        errors++;
                        $display("FAIL %s rnd: got %h want %h", e.name, bus.rnd, e.exp_r);
                    end
                end
                if (e.chk_mem) begin
                    for (int i = 0; i < RS; i++) begin
                        if (mem_vld[i]) begin
                            checks++;
                            if (dut.mem[i] !== mem_m[i]) begin
                                errors++;
                                $display("FAIL %s mem[%0d]: got %h want %h", e.name, i, dut.mem[i], mem_m[i]);
                            end
                        end
                    end
                end
            end
        end
    end

    initial begin
        logic [31:0] s;
        int          wait_cnt;
        for (int i = 0; i < RS; i++) mem_vld[i] = 1'b0;
        rnd_vld      = 1'b0;
        rnd_m        = '0;
        reset        = 1'b1;
        bus.seed     = 32'h0;
        bus.data_in  = '0;
        bus.w_addr   = '0;
        bus.w_enable = 1'b0;
        bus.r_addr   = '0;

        // Reset with a non-zero seed; hand-computed first LFSR step.
        step(1'b1, 32'hA1EF_CDE5, 8'h00, 6'd0, 1'b0, 6'd0, 1'b0, "reset_seed");
        step(1'b1, 32'hA1EF_CDE5, 8'h00, 6'd0, 1'b0, 6'd0, 1'b0, "reset_hold");
        step(1'b0, 32'h0, 8'h00, 6'd0, 1'b0, 6'd0, 1'b0, "lfsr_step1");
        if (rnd_m != 32'h43DF_9BCB) begin
            errors++;
            $display("FAIL lfsr_model: got %h want %h", rnd_m, 32'h43DF_9BCB);
        end

        // Zero seed must load 1.
        step(1'b1, 32'h0, 8'h00, 6'd0, 1'b0, 6'd0, 1'b0, "reset_seed0");
        step(1'b0, 32'h0, 8'h00, 6'd0, 1'b0, 6'd0, 1'b0, "seed0_step");

        // Zero-fill every address, then read every address back.
        for (int i = 0; i < RS; i++)
            step(1'b0, 32'h0, 8'h00, 6'(i), 1'b1, 6'd0, 1'b0, "zero_fill");
        for (int i = 0; i < RS; i++)
            step(1'b0, 32'h0, 8'h00, 6'd0, 1'b0, 6'(i), (i == RS - 1), "zero_read");

        // Write 5A to addr 7 and read it back; disabled write must not land.
        step(1'b0, 32'h0, 8'h5A, 6'd7, 1'b1, 6'd0, 1'b0, "wr_5a");
        step(1'b0, 32'h0, 8'hFF, 6'd7, 1'b0, 6'd7, 1'b0, "rd_5a");
        step(1'b0, 32'h0, 8'hFF, 6'd7, 1'b0, 6'd7, 1'b1, "rd_5a_hold");

        // Collision: read-before-write, new data on the next read.
        step(1'b0, 32'h0, 8'h11, 6'd3, 1'b1, 6'd0, 1'b0, "wr_11");
        step(1'b0, 32'h0, 8'h22, 6'd3, 1'b1, 6'd3, 1'b0, "collide_old");
        step(1'b0, 32'h0, 8'h00, 6'd0, 1'b0, 6'd3, 1'b0, "collide_new");

        // Reset mid-run with a pending write: write lands, data_out clears.
        step(1'b1, 32'h1234_5678, 8'h99, 6'd9, 1'b1, 6'd3, 1'b0, "reset_wr");
        step(1'b0, 32'h0, 8'h00, 6'd0, 1'b0, 6'd9, 1'b1, "reset_wr_rd");

        // Random traffic from independent slices of a bench LFSR.
        step(1'b1, 32'h0, 8'h00, 6'd0, 1'b0, 6'd0, 1'b0, "rand_reset");
        s = 32'hC0FF_EE01;
        for (int n = 0; n < RAND_CYCLES; n++) begin
            s = lfsr_next(s);
            step(1'b0, 32'h0, s[7:0], s[13:8], s[14], s[21:16],
                 (n % 1000 == 999), "random");
        end

        // Drain the scoreboard with a bounded wait.
        wait_cnt = 0;
        while (sb_q.size() != 0 && wait_cnt < 20) begin
            @(posedge clk);
            wait_cnt++;
        end
        #2;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending want 0", sb_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
